// File: rtl/branch_resolver_pkg.sv
// Shared constants and types for the execute-stage branch resolver.
// Holds the default widths and the flush FSM state encoding.
package branch_resolver_pkg;

    localparam int BR_WORD_SIZE    = 32;
    localparam int BR_NUM_LINES    = 4;
    localparam int BR_FLUSH_CYCLES = 2;
    localparam int BR_CNT_W        = 16;

    typedef enum logic [0:0] {
        RES_IDLE  = 1'b0,
        RES_FLUSH = 1'b1
    } resState_t;

endpackage

// File: rtl/branch_resolver_sat_counter.sv
// Saturating event counter: counts enabled cycles and sticks at all-ones.
module sat_counter
    import branch_resolver_pkg::*;
#(
    parameter int CNT_W = BR_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_r;

    // Count register, held once it reaches all-ones so statistics never wrap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_r <= {CNT_W{1'b0}};
        end else if (en && (count_r != {CNT_W{1'b1}})) begin
            count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign count = count_r;

endmodule

// File: rtl/branch_resolver.sv
// Execute-stage branch resolver: checks the fetch-time prediction against the
// real outcome, issues redirect + front-end flush, and trains the predictor.
module branch_resolver
    import branch_resolver_pkg::*;
#(
    parameter int WORD_SIZE    = BR_WORD_SIZE,
    parameter int NUM_LINES    = BR_NUM_LINES,
    parameter int IDX_W        = $clog2(NUM_LINES),
    parameter int FLUSH_CYCLES = BR_FLUSH_CYCLES,
    parameter int CNT_W        = BR_CNT_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WORD_SIZE-1:0] PCF,
    input  logic                 TakingBranchF,
    input  logic [WORD_SIZE-1:0] PredTargetF,
    input  logic                 StallF,
    input  logic                 StallD,
    input  logic                 ValidE,
    input  logic                 BranchE,
    input  logic                 ZeroE,
    input  logic [WORD_SIZE-1:0] PCE,
    input  logic [WORD_SIZE-1:0] PCTargetE,
    input  logic [WORD_SIZE-1:0] PCPlus4E,
    output logic                 RedirectValid,
    output logic [WORD_SIZE-1:0] RedirectPC,
    output logic                 FlushD,
    output logic                 FlushE,
    output logic                 UpdValid,
    output logic [IDX_W-1:0]     UpdIndex,
    output logic [WORD_SIZE-1:0] UpdPC,
    output logic [WORD_SIZE-1:0] UpdTarget,
    output logic                 UpdTaken,
    output logic                 UpdAlloc,
    output logic                 UpdInval,
    output logic [CNT_W-1:0]     BranchCount,
    output logic [CNT_W-1:0]     MispredCount
);

    localparam int FCW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [FCW-1:0] FLUSH_LAST = FCW'(FLUSH_CYCLES - 1);

    logic                 predTakenD_r, predValidD_r;
    logic [WORD_SIZE-1:0] predTargetD_r;
    logic                 predTakenE_r, predValidE_r, doneE_r;
    logic [WORD_SIZE-1:0] predTargetE_r;

    resState_t            state_r, stateNext_s;
    logic [FCW-1:0]       flushCnt_r, flushCntNext_s;

    logic                 res_s, actualTaken_s, mispred_s, aliasHit_s;
    logic [WORD_SIZE-1:0] redirTarget_s;

    logic                 flushNext_s, redirValidNext_s, updValidNext_s;
    logic                 updTakenNext_s, updAllocNext_s, updInvalNext_s;
    logic [WORD_SIZE-1:0] redirPCNext_s, updPCNext_s, updTargetNext_s;
    logic [IDX_W-1:0]     updIndexNext_s;

    logic                 flush_r, redirValid_r, updValid_r;
    logic                 updTaken_r, updAlloc_r, updInval_r;
    logic [WORD_SIZE-1:0] redirPC_r, updPC_r, updTarget_r;
    logic [IDX_W-1:0]     updIndex_r;

    // F->D prediction register; a flush kills the entry even while fetch stalls.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            predTakenD_r  <= 1'b0;
            predTargetD_r <= {WORD_SIZE{1'b0}};
            predValidD_r  <= 1'b0;
        end else begin
            if (!StallF) begin
                predTakenD_r  <= TakingBranchF;
                predTargetD_r <= PredTargetF;
            end
            if (flush_r) begin
                predValidD_r <= 1'b0;
            end else if (!StallF) begin
                predValidD_r <= 1'b1;
            end
        end
    end

    // D->E prediction register plus the resolved-once flag for stalled E.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            predTakenE_r  <= 1'b0;
            predTargetE_r <= {WORD_SIZE{1'b0}};
            predValidE_r  <= 1'b0;
            doneE_r       <= 1'b0;
        end else begin
            if (flush_r) begin
                predValidE_r <= 1'b0;
            end else if (!StallD) begin
                predTakenE_r  <= predTakenD_r;
                predTargetE_r <= predTargetD_r;
                predValidE_r  <= predValidD_r;
            end
            if (flush_r || !StallD) begin
                doneE_r <= 1'b0;
            end else if (res_s) begin
                doneE_r <= 1'b1;
            end
        end
    end

    // Mispredict classification; a non-branch predicted taken is a stale alias.
    always_comb begin
        res_s         = ValidE && predValidE_r && !doneE_r && (state_r == RES_IDLE);
        actualTaken_s = BranchE && ZeroE;
        aliasHit_s    = 1'b0;
        mispred_s     = 1'b0;
        redirTarget_s = PCPlus4E;
        if (!res_s) begin
            mispred_s = 1'b0;
        end else if (BranchE) begin
            if (actualTaken_s) begin
                mispred_s     = !predTakenE_r || (predTargetE_r != PCTargetE);
                redirTarget_s = PCTargetE;
            end else begin
                mispred_s = predTakenE_r;
            end
        end else begin
            aliasHit_s = predTakenE_r;
            mispred_s  = predTakenE_r;
        end
    end

    // Flush FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= RES_IDLE;
            flushCnt_r <= {FCW{1'b0}};
        end else begin
            state_r    <= stateNext_s;
            flushCnt_r <= flushCntNext_s;
        end
    end

    // Flush FSM next state: stay in FLUSH for FLUSH_CYCLES cycles.
    always_comb begin
        stateNext_s    = state_r;
        flushCntNext_s = flushCnt_r;
        case (state_r)
            RES_IDLE: begin
                if (mispred_s) begin
                    stateNext_s    = RES_FLUSH;
                    flushCntNext_s = {FCW{1'b0}};
                end else begin
                    stateNext_s = RES_IDLE;
                end
            end
            RES_FLUSH: begin
                if (flushCnt_r == FLUSH_LAST) begin
                    stateNext_s    = RES_IDLE;
                    flushCntNext_s = {FCW{1'b0}};
                end else begin
                    flushCntNext_s = flushCnt_r + {{(FCW-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                stateNext_s    = RES_IDLE;
                flushCntNext_s = {FCW{1'b0}};
            end
        endcase
    end

    // Output decode: next-cycle redirect, flush and predictor-update values.
    always_comb begin
        flushNext_s      = (stateNext_s == RES_FLUSH);
        redirValidNext_s = mispred_s;
        redirPCNext_s    = mispred_s ? redirTarget_s : {WORD_SIZE{1'b0}};
        updValidNext_s   = 1'b0;
        updIndexNext_s   = {IDX_W{1'b0}};
        updPCNext_s      = {WORD_SIZE{1'b0}};
        updTargetNext_s  = {WORD_SIZE{1'b0}};
        updTakenNext_s   = 1'b0;
        updAllocNext_s   = 1'b0;
        updInvalNext_s   = 1'b0;
        if (res_s && BranchE) begin
            updValidNext_s  = 1'b1;
            updIndexNext_s  = PCE[IDX_W+1:2];
            updPCNext_s     = PCE;
            updTargetNext_s = PCTargetE;
            updTakenNext_s  = ZeroE;
            updAllocNext_s  = actualTaken_s && !predTakenE_r;
        end else if (aliasHit_s) begin
            updValidNext_s = 1'b1;
            updIndexNext_s = PCE[IDX_W+1:2];
            updPCNext_s    = PCE;
            updInvalNext_s = 1'b1;
        end else begin
            updValidNext_s = 1'b0;
        end
    end

    // Registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            flush_r      <= 1'b0;
            redirValid_r <= 1'b0;
            redirPC_r    <= {WORD_SIZE{1'b0}};
            updValid_r   <= 1'b0;
            updIndex_r   <= {IDX_W{1'b0}};
            updPC_r      <= {WORD_SIZE{1'b0}};
            updTarget_r  <= {WORD_SIZE{1'b0}};
            updTaken_r   <= 1'b0;
            updAlloc_r   <= 1'b0;
            updInval_r   <= 1'b0;
        end else begin
            flush_r      <= flushNext_s;
            redirValid_r <= redirValidNext_s;
            redirPC_r    <= redirPCNext_s;
            updValid_r   <= updValidNext_s;
            updIndex_r   <= updIndexNext_s;
            updPC_r      <= updPCNext_s;
            updTarget_r  <= updTargetNext_s;
            updTaken_r   <= updTakenNext_s;
            updAlloc_r   <= updAllocNext_s;
            updInval_r   <= updInvalNext_s;
        end
    end

    assign RedirectValid = redirValid_r;
    assign RedirectPC    = redirPC_r;
    assign FlushD        = flush_r;
    assign FlushE        = flush_r;
    assign UpdValid      = updValid_r;
    assign UpdIndex      = updIndex_r;
    assign UpdPC         = updPC_r;
    assign UpdTarget     = updTarget_r;
    assign UpdTaken      = updTaken_r;
    assign UpdAlloc      = updAlloc_r;
    assign UpdInval      = updInval_r;

    sat_counter #(.CNT_W(CNT_W)) uBranchCnt (
        .clk   (clk),
        .rst   (rst),
        .en    (res_s && BranchE),
        .count (BranchCount)
    );

    sat_counter #(.CNT_W(CNT_W)) uMispredCnt (
        .clk   (clk),
        .rst   (rst),
        .en    (mispred_s),
        .count (MispredCount)
    );

endmodule

// File: tb/tb_branch_resolver.sv
// Scoreboard bench for branch_resolver: each transaction pushes the expected
// per-cycle outputs, which are popped and compared on the following cycles.
module tb_branch_resolver;

    localparam int TB_CNT_W = 8;

    logic        clk, rst;
    logic [31:0] PCF, PredTargetF, PCE, PCTargetE, PCPlus4E;
    logic        TakingBranchF, StallF, StallD, ValidE, BranchE, ZeroE;
    logic        RedirectValid, FlushD, FlushE, UpdValid, UpdTaken, UpdAlloc, UpdInval;
    logic [31:0] RedirectPC, UpdPC, UpdTarget;
    logic [1:0]  UpdIndex;
    logic [TB_CNT_W-1:0] BranchCount, MispredCount;

    branch_resolver #(.CNT_W(TB_CNT_W)) dut (
        .clk(clk), .rst(rst), .PCF(PCF), .TakingBranchF(TakingBranchF),
        .PredTargetF(PredTargetF), .StallF(StallF), .StallD(StallD),
        .ValidE(ValidE), .BranchE(BranchE), .ZeroE(ZeroE), .PCE(PCE),
        .PCTargetE(PCTargetE), .PCPlus4E(PCPlus4E),
        .RedirectValid(RedirectValid), .RedirectPC(RedirectPC),
        .FlushD(FlushD), .FlushE(FlushE), .UpdValid(UpdValid),
        .UpdIndex(UpdIndex), .UpdPC(UpdPC), .UpdTarget(UpdTarget),
        .UpdTaken(UpdTaken), .UpdAlloc(UpdAlloc), .UpdInval(UpdInval),
        .BranchCount(BranchCount), .MispredCount(MispredCount)
    );

    typedef struct {
        logic        rv;
        logic [31:0] rpc;
        logic        fl;
        logic        uv;
        logic [1:0]  ui;
        logic [31:0] upc;
        logic [31:0] utg;
        logic        chkTgt;
        logic        ut, ua, uinv;
        int          bc, mc;
    } exp_t;

    exp_t  expQ[$];
    string tagQ[$];
    int    nCompared = 0;
    int    nMismatch = 0;
    int    expBc = 0;
    int    expMc = 0;
    int    satMax = (1 << TB_CNT_W) - 1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nCompared++;
        if (got !== exp) begin
            nMismatch++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic exp_t quietRec(input logic fl);
        exp_t r;
        r.rv = 1'b0; r.rpc = 32'h0; r.fl = fl; r.uv = 1'b0; r.ui = 2'b00;
        r.upc = 32'h0; r.utg = 32'h0; r.chkTgt = 1'b1;
        r.ut = 1'b0; r.ua = 1'b0; r.uinv = 1'b0;
        r.bc = expBc; r.mc = expMc;
        return r;
    endfunction

    task automatic pushExp(input string tag, input exp_t r);
        expQ.push_back(r);
        tagQ.push_back(tag);
    endtask

    task automatic tick();
        exp_t  r;
        string t;
        @(posedge clk);
        @(negedge clk);
        if (expQ.size() > 0) begin
            r = expQ.pop_front();
            t = tagQ.pop_front();
            checkVal({t, ".redirectValid"}, 32'(RedirectValid), 32'(r.rv));
            if (r.rv) checkVal({t, ".redirectPC"}, RedirectPC, r.rpc);
            checkVal({t, ".flushD"}, 32'(FlushD), 32'(r.fl));
            checkVal({t, ".flushE"}, 32'(FlushE), 32'(r.fl));
            checkVal({t, ".updValid"}, 32'(UpdValid), 32'(r.uv));
            checkVal({t, ".updIndex"}, 32'(UpdIndex), 32'(r.ui));
            checkVal({t, ".updPC"}, UpdPC, r.upc);
            if (r.chkTgt) checkVal({t, ".updTarget"}, UpdTarget, r.utg);
            checkVal({t, ".updTaken"}, 32'(UpdTaken), 32'(r.ut));
            checkVal({t, ".updAlloc"}, 32'(UpdAlloc), 32'(r.ua));
            checkVal({t, ".updInval"}, 32'(UpdInval), 32'(r.uinv));
            checkVal({t, ".branchCount"}, 32'(BranchCount), 32'(r.bc));
            checkVal({t, ".mispredCount"}, 32'(MispredCount), 32'(r.mc));
        end
    endtask

    task automatic idleE();
        ValidE = 1'b0; BranchE = 1'b0; ZeroE = 1'b0;
        PCE = 32'h0; PCTargetE = 32'h0; PCPlus4E = 32'h0;
    endtask

    task automatic checkAllZero(input string tag);
        checkVal({tag, ".redirectValid"}, 32'(RedirectValid), 32'h0);
        checkVal({tag, ".redirectPC"}, RedirectPC, 32'h0);
        checkVal({tag, ".flushD"}, 32'(FlushD), 32'h0);
        checkVal({tag, ".flushE"}, 32'(FlushE), 32'h0);
        checkVal({tag, ".updValid"}, 32'(UpdValid), 32'h0);
        checkVal({tag, ".updAlloc"}, 32'(UpdAlloc), 32'h0);
        checkVal({tag, ".updPC"}, UpdPC, 32'h0);
        checkVal({tag, ".branchCount"}, 32'(BranchCount), 32'h0);
        checkVal({tag, ".mispredCount"}, 32'(MispredCount), 32'h0);
    endtask

    // One instruction: prediction enters F, resolves in E two cycles later.
    task automatic runTxn(input string tag, input bit pTaken, input logic [31:0] pTgt,
                          input bit br, input bit zr, input logic [31:0] pce,
                          input logic [31:0] ptgt, input bit b2b, input bit stall,
                          input bit midReset);
        bit          mis;
        logic [31:0] rt;
        exp_t        r;
        PCF = pce; TakingBranchF = pTaken; PredTargetF = pTgt; idleE();
        tick();
        PCF = pce + 32'd4; TakingBranchF = 1'b0; PredTargetF = 32'h0;
        tick();
        mis = 1'b0; rt = pce + 32'd4;
        if (br) begin
            if (zr && !pTaken)                    begin mis = 1'b1; rt = ptgt; end
            else if (!zr && pTaken)               begin mis = 1'b1; rt = pce + 32'd4; end
            else if (zr && pTaken && pTgt != ptgt) begin mis = 1'b1; rt = ptgt; end
        end else begin
            mis = pTaken;
        end
        if (br && expBc < satMax) expBc++;
        if (mis && expMc < satMax) expMc++;
        r = quietRec(mis);
        r.rv = mis; r.rpc = rt;
        if (br) begin
            r.uv = 1'b1; r.ui = pce[3:2]; r.upc = pce; r.utg = ptgt;
            r.ut = zr; r.ua = zr && !pTaken;
        end else if (mis) begin
            r.uv = 1'b1; r.ui = pce[3:2]; r.upc = pce; r.uinv = 1'b1; r.chkTgt = 1'b0;
        end
        ValidE = 1'b1; BranchE = br; ZeroE = zr; PCE = pce;
        PCTargetE = ptgt; PCPlus4E = pce + 32'd4; StallD = stall;
        pushExp({tag, "@N+1"}, r);
        tick();
        if (midReset) begin
            rst = 1'b0;
            #1;
            expBc = 0; expMc = 0;
            checkAllZero({tag, ".inReset"});
            #1 rst = 1'b1;
            idleE(); StallD = 1'b0;
            pushExp({tag, "@postReset1"}, quietRec(1'b0));
            tick();
            pushExp({tag, "@postReset2"}, quietRec(1'b0));
            tick();
            return;
        end
        if (b2b) begin
            ValidE = 1'b1; BranchE = 1'b1; ZeroE = 1'b1; PCE = pce + 32'd8;
            PCTargetE = 32'h100; PCPlus4E = pce + 32'd12;
        end else if (!stall) begin
            idleE();
        end
        pushExp({tag, "@N+2"}, quietRec(mis));
        tick();
        idleE(); StallD = 1'b0;
        pushExp({tag, "@N+3"}, quietRec(1'b0));
        tick();
    endtask

    initial begin
        rst = 1'b0; StallF = 1'b0; StallD = 1'b0;
        PCF = 32'h0; TakingBranchF = 1'b0; PredTargetF = 32'h0;
        idleE();
        #3;
        checkAllZero("reset");
        @(negedge clk);
        rst = 1'b1;
        tick();

        runTxn("caseA",       1'b0, 32'h0,  1'b1, 1'b1, 32'h10, 32'h40, 1'b0, 1'b0, 1'b0);
        runTxn("caseB",       1'b1, 32'h40, 1'b1, 1'b0, 32'h14, 32'h40, 1'b0, 1'b0, 1'b0);
        runTxn("correctT",    1'b1, 32'h40, 1'b1, 1'b1, 32'h20, 32'h40, 1'b0, 1'b0, 1'b0);
        runTxn("caseC",       1'b1, 32'h80, 1'b1, 1'b1, 32'h24, 32'h40, 1'b0, 1'b0, 1'b0);
        runTxn("caseD",       1'b1, 32'h40, 1'b0, 1'b0, 32'h28, 32'h40, 1'b0, 1'b0, 1'b0);
        runTxn("correctNT",   1'b0, 32'h0,  1'b1, 1'b0, 32'h2C, 32'h90, 1'b0, 1'b0, 1'b0);
        runTxn("plainInstr",  1'b0, 32'h0,  1'b0, 1'b1, 32'h30, 32'h90, 1'b0, 1'b0, 1'b0);
        runTxn("backToBack",  1'b0, 32'h0,  1'b1, 1'b1, 32'h34, 32'h60, 1'b1, 1'b0, 1'b0);
        runTxn("stallE",      1'b1, 32'h70, 1'b1, 1'b1, 32'h38, 32'h70, 1'b0, 1'b1, 1'b0);

        for (int i = 0; i < satMax + 4; i++) begin
            runTxn("saturate", 1'b0, 32'h0, 1'b1, 1'b1, 32'h40 + 32'(4 * (i % 8)),
                   32'h200, 1'b0, 1'b0, 1'b0);
        end
        checkVal("satBranchCount", 32'(BranchCount), 32'(satMax));
        checkVal("satMispredCount", 32'(MispredCount), 32'(satMax));

        runTxn("midFlushReset", 1'b0, 32'h0, 1'b1, 1'b1, 32'h18, 32'h44, 1'b0, 1'b0, 1'b1);
        runTxn("afterReset",    1'b1, 32'h44, 1'b1, 1'b1, 32'h1C, 32'h44, 1'b0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
        $finish;
    end

endmodule
